// File: rtl/time_setting_ctrl_pkg.sv
// Shared definitions for the time-setting controller: FSM states, ASCII glyphs,
// button bit positions and small field/digit helpers.
package time_setting_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SET_H = 3'd1,
        SET_M = 3'd2,
        SET_S = 3'd3,
        LOAD  = 3'd4
    } state_t;

    localparam logic [7:0] CH_SP    = 8'h20;
    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_COLON = 8'h3A;
    localparam logic [7:0] CH_A     = 8'h41;
    localparam logic [7:0] CH_P     = 8'h50;
    localparam logic [7:0] CH_M     = 8'h4D;

    localparam logic [127:0] LINE1_TXT = "    Time set    ";

    localparam int BTN_UP     = 15;
    localparam int BTN_DN     = 14;
    localparam int BTN_NEXT   = 13;
    localparam int BTN_CANCEL = 1;
    localparam int BTN_OK     = 0;

    function automatic logic [6:0] wrap_inc(input logic [6:0] v, input int max);
        return (v >= 7'(max)) ? 7'd0 : v + 7'd1;
    endfunction

    function automatic logic [6:0] wrap_dec(input logic [6:0] v, input int max);
        return (v == 7'd0 || v > 7'(max)) ? 7'(max) : v - 7'd1;
    endfunction

    // Two ASCII digits {tens, units} for a value 0..99.
    function automatic logic [15:0] two_digits(input logic [6:0] v);
        logic [6:0] t;
        logic [6:0] u;
        t = v / 7'd10;
        u = v % 7'd10;
        return {CH_0 + {1'b0, t}, CH_0 + {1'b0, u}};
    endfunction

endpackage

// File: rtl/time_setting_ctrl_btn_repeat.sv
// Button rising-edge pulser with optional hold-to-repeat: pulses at the press edge,
// again HOLD_MS cycles later, then every REPEAT_MS cycles while held.
module btn_repeat #(
    parameter int HOLD_MS   = 500,
    parameter int REPEAT_MS = 100,
    parameter bit REPEAT_EN = 1'b1
) (
    input  logic clk_1kHz,
    input  logic resetn,
    input  logic i_btn,
    output logic o_pulse
);
    localparam int HW = $clog2(HOLD_MS + 1);
    localparam int RW = $clog2(REPEAT_MS + 1);
    localparam logic [HW-1:0] HOLD_C = HW'(HOLD_MS);
    localparam logic [RW-1:0] REP_C  = RW'(REPEAT_MS);

    logic          btn_q;
    logic          rpt_q, rpt_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [RW-1:0] rep_q, rep_d;
    logic          edge_w, fire_w;

    assign edge_w  = i_btn & ~btn_q;
    assign o_pulse = edge_w | fire_w;

    // hold_q counts held cycles since the press edge; rep_q counts within a repeat period.
    always_comb begin
        hold_d = hold_q;
        rep_d  = rep_q;
        rpt_d  = rpt_q;
        fire_w = 1'b0;
        if (!i_btn || !REPEAT_EN) begin
            hold_d = '0;
            rep_d  = '0;
            rpt_d  = 1'b0;
        end else if (edge_w) begin
            hold_d = HW'(1);
            rep_d  = '0;
            rpt_d  = 1'b0;
        end else if (!rpt_q) begin
            if (hold_q == HOLD_C) begin
                fire_w = 1'b1;
                rpt_d  = 1'b1;
                rep_d  = RW'(1);
            end else begin
                hold_d = hold_q + 1'b1;
            end
        end else begin
            if (rep_q == REP_C) begin
                fire_w = 1'b1;
                rep_d  = RW'(1);
            end else begin
                rep_d = rep_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_1kHz) begin
        if (!resetn) begin
            btn_q  <= 1'b0;
            rpt_q  <= 1'b0;
            hold_q <= '0;
            rep_q  <= '0;
        end else begin
            btn_q  <= i_btn;
            rpt_q  <= rpt_d;
            hold_q <= hold_d;
            rep_q  <= rep_d;
        end
    end

endmodule

// File: rtl/time_setting_ctrl.sv
// Time-setting controller: field-select edit FSM, LCD text and one-cycle load strobe.
// Optional blinking of the selected field is enabled by defining TIME_SET_BLINK_EN.
module time_setting_ctrl #(
    parameter int HOLD_MS   = 500,
    parameter int REPEAT_MS = 100,
    parameter int H_MAX     = 23,
    parameter int MS_MAX    = 59
) (
    input  logic         clk_1kHz,
    input  logic         resetn,
    input  logic [15:0]  i_btns,
    input  logic         i_enter,
    input  logic [20:0]  i_cur_data,
    input  logic         i_mode_12h,
    output logic [127:0] o_line1,
    output logic [127:0] o_line2,
    output logic [20:0]  o_load_data,
    output logic         o_load_sig,
    output logic         o_active
);
    import time_setting_ctrl_pkg::*;

    state_t     state_q, state_d;
    logic [6:0] h_q, h_d, m_q, m_d, s_q, s_d;
    logic       up_p, dn_p, nx_p, cn_p, ok_p;
    logic       unused_btns;

    assign unused_btns = ^i_btns[12:2];

    btn_repeat #(.HOLD_MS(HOLD_MS), .REPEAT_MS(REPEAT_MS), .REPEAT_EN(1'b1)) u_up (
        .clk_1kHz(clk_1kHz), .resetn(resetn), .i_btn(i_btns[BTN_UP]), .o_pulse(up_p));
    btn_repeat #(.HOLD_MS(HOLD_MS), .REPEAT_MS(REPEAT_MS), .REPEAT_EN(1'b1)) u_dn (
        .clk_1kHz(clk_1kHz), .resetn(resetn), .i_btn(i_btns[BTN_DN]), .o_pulse(dn_p));
    btn_repeat #(.HOLD_MS(HOLD_MS), .REPEAT_MS(REPEAT_MS), .REPEAT_EN(1'b0)) u_nx (
        .clk_1kHz(clk_1kHz), .resetn(resetn), .i_btn(i_btns[BTN_NEXT]), .o_pulse(nx_p));
    btn_repeat #(.HOLD_MS(HOLD_MS), .REPEAT_MS(REPEAT_MS), .REPEAT_EN(1'b0)) u_cn (
        .clk_1kHz(clk_1kHz), .resetn(resetn), .i_btn(i_btns[BTN_CANCEL]), .o_pulse(cn_p));
    btn_repeat #(.HOLD_MS(HOLD_MS), .REPEAT_MS(REPEAT_MS), .REPEAT_EN(1'b0)) u_ok (
        .clk_1kHz(clk_1kHz), .resetn(resetn), .i_btn(i_btns[BTN_OK]), .o_pulse(ok_p));

    // Priority inside SET_*: cancel, confirm, next field, then a single up or down step.
    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        m_d     = m_q;
        s_d     = s_q;
        case (state_q)
            IDLE: begin
                if (i_enter) begin
                    h_d     = i_cur_data[20:14];
                    m_d     = i_cur_data[13:7];
                    s_d     = i_cur_data[6:0];
                    state_d = SET_H;
                end
            end
            SET_H, SET_M, SET_S: begin
                if (cn_p) begin
                    state_d = IDLE;
                end else if (ok_p) begin
                    state_d = LOAD;
                end else if (nx_p) begin
                    state_d = (state_q == SET_H) ? SET_M :
                              (state_q == SET_M) ? SET_S : SET_H;
                end else if (up_p ^ dn_p) begin
                    case (state_q)
                        SET_H:   h_d = up_p ? wrap_inc(h_q, H_MAX)  : wrap_dec(h_q, H_MAX);
                        SET_M:   m_d = up_p ? wrap_inc(m_q, MS_MAX) : wrap_dec(m_q, MS_MAX);
                        default: s_d = up_p ? wrap_inc(s_q, MS_MAX) : wrap_dec(s_q, MS_MAX);
                    endcase
                end
            end
            LOAD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_1kHz) begin
        if (!resetn) begin
            state_q <= IDLE;
            h_q     <= 7'd0;
            m_q     <= 7'd0;
            s_q     <= 7'd0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            m_q     <= m_d;
            s_q     <= s_d;
        end
    end

    assign o_active    = (state_q == SET_H) || (state_q == SET_M) || (state_q == SET_S);
    assign o_load_sig  = (state_q == LOAD);
    assign o_load_data = {h_q, m_q, s_q};
    assign o_line1     = LINE1_TXT;

`ifdef TIME_SET_BLINK_EN
    logic [9:0] blink_q;
    logic       blink_clr, blink_on;

    // Restart the blink phase on any field or value change so edits show at once.
    assign blink_clr = (state_d != state_q) || (h_d != h_q) || (m_d != m_q) || (s_d != s_q);
    assign blink_on  = (blink_q >= 10'd500);

    always_ff @(posedge clk_1kHz) begin
        if (!resetn || blink_clr || blink_q == 10'd999) begin
            blink_q <= 10'd0;
        end else begin
            blink_q <= blink_q + 10'd1;
        end
    end
`endif

    logic [6:0]  disp_h;
    logic [15:0] hh, mm, ss, ampm;

    always_comb begin
        disp_h = h_q;
        if (i_mode_12h) begin
            if (h_q == 7'd0) begin
                disp_h = 7'd12;
            end else if (h_q > 7'd12) begin
                disp_h = h_q - 7'd12;
            end
        end
        hh   = two_digits(disp_h);
        mm   = two_digits(m_q);
        ss   = two_digits(s_q);
        ampm = i_mode_12h ? {((h_q >= 7'd12) ? CH_P : CH_A), CH_M} : {CH_SP, CH_SP};
`ifdef TIME_SET_BLINK_EN
        if (blink_on) begin
            case (state_q)
                SET_H:   hh = {CH_SP, CH_SP};
                SET_M:   mm = {CH_SP, CH_SP};
                SET_S:   ss = {CH_SP, CH_SP};
                default: ;
            endcase
        end
`endif
        o_line2 = {CH_SP, CH_SP, CH_SP, hh, CH_COLON, mm, CH_COLON, ss,
                   CH_SP, ampm, CH_SP, CH_SP};
    end

endmodule

// File: tb/tb_time_setting_ctrl.sv
// Directed table-driven bench for time_setting_ctrl, plus hand-written hold-repeat
// and mid-edit reset sequences.
module tb_time_setting_ctrl;

  localparam logic [15:0] B_UP = 16'h8000;
  localparam logic [15:0] B_DN = 16'h4000;
  localparam logic [15:0] B_NX = 16'h2000;
  localparam logic [15:0] B_CN = 16'h0002;
  localparam logic [15:0] B_OK = 16'h0001;

  typedef struct {
    logic [15:0]  btns;
    logic         enter;
    logic [20:0]  cur;
    logic         m12;
    logic         act;
    logic         ld;
    logic [20:0]  data;
    logic [127:0] l2;
  } vec_t;

  // clock / reset
  logic         clk = 1'b0;
  logic         resetn;
  logic [15:0]  btns;
  logic         enter;
  logic [20:0]  cur;
  logic         m12;
  logic [127:0] o_line1, o_line2;
  logic [20:0]  o_load_data;
  logic         o_load_sig, o_active;

  always #5 clk = ~clk;

  time_setting_ctrl #(.HOLD_MS(500), .REPEAT_MS(100), .H_MAX(23), .MS_MAX(59)) dut (
    .clk_1kHz(clk), .resetn(resetn), .i_btns(btns), .i_enter(enter),
    .i_cur_data(cur), .i_mode_12h(m12), .o_line1(o_line1), .o_line2(o_line2),
    .o_load_data(o_load_data), .o_load_sig(o_load_sig), .o_active(o_active));

  // scoreboard
  int n_vec = 0;
  int n_bad = 0;
  int load_cnt = 0;
  vec_t vecs[0:29];

  always @(negedge clk) if (o_load_sig === 1'b1) load_cnt++;

  function automatic logic [20:0] hms(input int h, input int m, input int s);
    return {7'(h), 7'(m), 7'(s)};
  endfunction

  function automatic vec_t mk(input logic [15:0] b, input logic e, input logic [20:0] c,
                              input logic md, input logic a, input logic l,
                              input logic [20:0] d, input logic [127:0] t);
    vec_t v;
    v.btns = b; v.enter = e; v.cur = c; v.m12 = md;
    v.act = a; v.ld = l; v.data = d; v.l2 = t;
    return v;
  endfunction

  task automatic chk_v(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_l(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got '%s' expected '%s'", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic a, input logic l,
                           input logic [20:0] d, input logic [127:0] t);
    chk_v({tag, " active"}, 32'(o_active), 32'(a));
    chk_v({tag, " load_sig"}, 32'(o_load_sig), 32'(l));
    chk_v({tag, " load_data"}, 32'(o_load_data), 32'(d));
    chk_l({tag, " line2"}, o_line2, t);
  endtask

  // driver
  task automatic apply(input int i);
    btns  = vecs[i].btns;
    enter = vecs[i].enter;
    cur   = vecs[i].cur;
    m12   = vecs[i].m12;
    @(posedge clk); #1;
    check_out($sformatf("v%0d", i), vecs[i].act, vecs[i].ld, vecs[i].data, vecs[i].l2);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = mk(16'h0, 1, hms(23,59,58), 0, 1, 0, hms(23,59,58), "   23:59:58     ");
    vecs[1]  = mk(B_UP,  0, 21'h0,         0, 1, 0, hms(0,59,58),  "   00:59:58     ");
    vecs[2]  = mk(16'h0, 0, 21'h0,         0, 1, 0, hms(0,59,58),  "   00:59:58     ");
    vecs[3]  = mk(B_NX,  0, 21'h0,         0, 1, 0, hms(0,59,58),  "   00:59:58     ");
    vecs[4]  = mk(16'h0, 0, 21'h0,         0, 1, 0, hms(0,59,58),  "   00:59:58     ");
    vecs[5]  = mk(B_DN,  0, 21'h0,         0, 1, 0, hms(0,58,58),  "   00:58:58     ");
    vecs[6]  = mk(16'h0, 0, 21'h0,         0, 1, 0, hms(0,58,58),  "   00:58:58     ");
    vecs[7]  = mk(B_NX,  0, 21'h0,         0, 1, 0, hms(0,58,58),  "   00:58:58     ");
    vecs[8]  = mk(16'h0, 0, 21'h0,         0, 1, 0, hms(0,58,58),  "   00:58:58     ");
    vecs[9]  = mk(B_NX,  0, 21'h0,         0, 1, 0, hms(0,58,5),   "   00:58:05     ");
    vecs[10] = mk(16'h0, 0, 21'h0,         0, 1, 0, hms(0,58,5),   "   00:58:05     ");
    vecs[11] = mk(B_DN,  0, 21'h0,         0, 1, 0, hms(23,58,5),  "   23:58:05     ");
    vecs[12] = mk(16'h0, 0, 21'h0,         0, 1, 0, hms(23,58,5),  "   23:58:05     ");
    vecs[13] = mk(B_NX,  0, 21'h0,         0, 1, 0, hms(23,58,5),  "   23:58:05     ");
    vecs[14] = mk(16'h0, 0, 21'h0,         0, 1, 0, hms(23,58,5),  "   23:58:05     ");
    vecs[15] = mk(B_OK,  0, 21'h0,         0, 0, 1, hms(23,58,5),  "   23:58:05     ");
    vecs[16] = mk(16'h0, 0, 21'h0,         0, 0, 0, hms(23,58,5),  "   23:58:05     ");
    vecs[17] = mk(B_UP,  0, 21'h0,         0, 0, 0, hms(23,58,5),  "   23:58:05     ");
    vecs[18] = mk(16'h0, 1, hms(0,7,9),    1, 1, 0, hms(0,7,9),    "   12:07:09 AM  ");
    vecs[19] = mk(B_CN | B_OK, 0, 21'h0,   1, 0, 0, hms(0,7,9),    "   12:07:09 AM  ");
    vecs[20] = mk(16'h0, 0, 21'h0,         1, 0, 0, hms(0,7,9),    "   12:07:09 AM  ");
    vecs[21] = mk(16'h0, 1, hms(13,0,0),   1, 1, 0, hms(13,0,0),   "   01:00:00 PM  ");
    vecs[22] = mk(16'h0, 0, 21'h0,         1, 1, 0, hms(13,0,0),   "   01:00:00 PM  ");
    vecs[23] = mk(B_DN,  0, 21'h0,         1, 1, 0, hms(12,0,0),   "   12:00:00 PM  ");
    vecs[24] = mk(16'h0, 0, 21'h0,         0, 1, 0, hms(12,0,0),   "   12:00:00     ");
    vecs[25] = mk(B_UP,  0, 21'h0,         0, 1, 0, hms(13,0,0),   "   13:00:00     ");
    vecs[26] = mk(B_CN,  0, 21'h0,         0, 0, 0, hms(13,0,0),   "   13:00:00     ");
    vecs[27] = mk(16'h0, 1, hms(5,6,7),    0, 1, 0, hms(5,6,7),    "   05:06:07     ");
    vecs[28] = mk(B_NX,  0, 21'h0,         0, 1, 0, hms(5,6,7),    "   05:06:07     ");
    vecs[29] = mk(16'h0, 0, 21'h0,         0, 1, 0, hms(5,6,7),    "   05:06:07     ");

    resetn = 1'b0; btns = '0; enter = 1'b0; cur = '0; m12 = 1'b0;
    cycles(3);
    check_out("reset", 0, 0, 21'h0, "   00:00:00     ");
    chk_l("reset line1", o_line1, "    Time set    ");
    resetn = 1'b1;
    cycles(2);

    for (int i = 0; i <= 8; i++) apply(i);
    chk_l("set line1", o_line1, "    Time set    ");

    // Hold up in SET_S: pulses at press edge and edge+500, then every 100 cycles.
    btns = B_UP;
    cycles(501);
    check_out("hold500", 1, 0, hms(0,58,0), "   00:58:00     ");
    cycles(500);
    check_out("hold1000", 1, 0, hms(0,58,5), "   00:58:05     ");
    btns = '0;
    cycles(5);
    check_out("hold_rel", 1, 0, hms(0,58,5), "   00:58:05     ");

    for (int i = 9; i <= 29; i++) apply(i);

    // Reset while up is held in SET_M discards the edit and never strobes.
    btns = B_UP;
    cycles(200);
    check_out("pre_rst", 1, 0, hms(5,7,7), "   05:07:07     ");
    resetn = 1'b0;
    cycles(1);
    check_out("mid_rst", 0, 0, 21'h0, "   00:00:00     ");
    cycles(1);
    resetn = 1'b1;
    cycles(600);
    check_out("post_rst", 0, 0, 21'h0, "   00:00:00     ");
    btns = '0;
    cycles(2);
    chk_v("load_strobes", 32'(load_cnt), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
